// File: rtl/systolic_tile_ctrl.sv
// Tiled matmul sequencer for the 2x2 systolic array.
// Walks output tiles row-major, runs every K pass, streams result tiles.
module systolic_tile_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACCUM_WIDTH = 64,
  parameter int DIM_W       = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [DIM_W-1:0]       m_tiles_i,
  input  logic [DIM_W-1:0]       n_tiles_i,
  input  logic [DIM_W-1:0]       k_tiles_i,
  input  logic                   abort_i,
  output logic                   fetch_req_o,
  output logic [DIM_W-1:0]       fetch_ti_o,
  output logic [DIM_W-1:0]       fetch_tj_o,
  output logic [DIM_W-1:0]       fetch_kt_o,
  output logic                   fetch_sub_o,
  input  logic                   fetch_valid_i,
  input  logic [DATA_WIDTH-1:0]  fetch_a0_i,
  input  logic [DATA_WIDTH-1:0]  fetch_a1_i,
  input  logic [DATA_WIDTH-1:0]  fetch_b0_i,
  input  logic [DATA_WIDTH-1:0]  fetch_b1_i,
  output logic                   arr_start_o,
  output logic                   arr_clear_o,
  output logic                   arr_accumulate_o,
  output logic                   arr_a_valid_o,
  output logic                   arr_b_valid_o,
  output logic [DATA_WIDTH-1:0]  arr_a_row0_o,
  output logic [DATA_WIDTH-1:0]  arr_a_row1_o,
  output logic [DATA_WIDTH-1:0]  arr_b_col0_o,
  output logic [DATA_WIDTH-1:0]  arr_b_col1_o,
  input  logic                   arr_done_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c00_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c01_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c10_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c11_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [DIM_W-1:0]       res_ti_o,
  output logic [DIM_W-1:0]       res_tj_o,
  output logic [ACCUM_WIDTH-1:0] res_c00_o,
  output logic [ACCUM_WIDTH-1:0] res_c01_o,
  output logic [ACCUM_WIDTH-1:0] res_c10_o,
  output logic [ACCUM_WIDTH-1:0] res_c11_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_FEED,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] ti_q, tj_q, kt_q;
  logic             sub_q;
  logic             acc_q;
  logic             err_q;
  logic [TW-1:0]    tmo_q;

  logic cmd_zero;
  logic last_k, last_i, last_j;
  logic in_feed, in_write, feed_ok;

  assign cmd_zero = (m_tiles_i == '0) ||
                    (n_tiles_i == '0) ||
                    (k_tiles_i == '0);
  assign last_k = kt_q == k_q - DIM_W'(1);
  assign last_i = ti_q == m_q - DIM_W'(1);
  assign last_j = tj_q == n_q - DIM_W'(1);

  assign in_feed  = state_q == S_FEED;
  assign in_write = state_q == S_WRITE;
  assign feed_ok  = in_feed && fetch_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      ti_q    <= '0;
      tj_q    <= '0;
      kt_q    <= '0;
      sub_q   <= 1'b0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        acc_q   <= 1'b0;
        sub_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cmd_valid_i) begin
              m_q  <= m_tiles_i;
              n_q  <= n_tiles_i;
              k_q  <= k_tiles_i;
              ti_q <= '0;
              tj_q <= '0;
              kt_q <= '0;
              if (cmd_zero) err_q   <= 1'b1;
              else          state_q <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            acc_q   <= 1'b0;
            state_q <= S_START;
          end
          S_START: begin
            sub_q   <= 1'b0;
            state_q <= S_FEED;
          end
          S_FEED: begin
            if (fetch_valid_i) begin
              if (sub_q) begin
                sub_q   <= 1'b0;
                tmo_q   <= '0;
                state_q <= S_WAIT;
              end else begin
                sub_q <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (arr_done_i) begin
              acc_q <= 1'b1;
              if (last_k) begin
                state_q <= S_WRITE;
              end else begin
                kt_q    <= kt_q + DIM_W'(1);
                state_q <= S_START;
              end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          S_WRITE: begin
            if (res_ready_i) begin
              kt_q  <= '0;
              acc_q <= 1'b0;
              if (last_j) begin
                tj_q <= '0;
                ti_q <= last_i ? '0 : ti_q + DIM_W'(1);
              end else begin
                tj_q <= tj_q + DIM_W'(1);
              end
              state_q <= (last_i && last_j) ? S_FINISH : S_CLEAR;
            end
          end
          S_FINISH: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o = state_q == S_IDLE;
  assign busy_o      = state_q != S_IDLE;
  assign done_o      = state_q == S_FINISH;
  assign err_o       = err_q;

  assign fetch_req_o = in_feed;
  assign fetch_ti_o  = ti_q;
  assign fetch_tj_o  = tj_q;
  assign fetch_kt_o  = kt_q;
  assign fetch_sub_o = sub_q;

  assign arr_clear_o      = state_q == S_CLEAR;
  assign arr_start_o      = state_q == S_START;
  assign arr_accumulate_o = acc_q;
  assign arr_a_valid_o    = feed_ok;
  assign arr_b_valid_o    = feed_ok;
  assign arr_a_row0_o     = feed_ok ? fetch_a0_i : '0;
  assign arr_a_row1_o     = feed_ok ? fetch_a1_i : '0;
  assign arr_b_col0_o     = feed_ok ? fetch_b0_i : '0;
  assign arr_b_col1_o     = feed_ok ? fetch_b1_i : '0;

  assign res_valid_o = in_write;
  assign res_ti_o    = in_write ? ti_q : '0;
  assign res_tj_o    = in_write ? tj_q : '0;
  assign res_c00_o   = in_write ? arr_c00_i : '0;
  assign res_c01_o   = in_write ? arr_c01_i : '0;
  assign res_c10_o   = in_write ? arr_c10_i : '0;
  assign res_c11_o   = in_write ? arr_c11_i : '0;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: operand buffer and array model
// plus a result scoreboard checked on every result handshake.
module tb_systolic_tile_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 64;
  localparam int DIM = 4;
  localparam int TMO = 64;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [DIM-1:0] m_tiles_i, n_tiles_i, k_tiles_i;
  logic           abort_i;
  logic           fetch_req_o;
  logic [DIM-1:0] fetch_ti_o, fetch_tj_o, fetch_kt_o;
  logic           fetch_sub_o;
  logic           fetch_valid_i;
  logic [DW-1:0]  fetch_a0_i, fetch_a1_i, fetch_b0_i, fetch_b1_i;
  logic           arr_start_o, arr_clear_o, arr_accumulate_o;
  logic           arr_a_valid_o, arr_b_valid_o;
  logic [DW-1:0]  arr_a_row0_o, arr_a_row1_o;
  logic [DW-1:0]  arr_b_col0_o, arr_b_col1_o;
  logic           arr_done_i;
  logic [AW-1:0]  arr_c00_i, arr_c01_i, arr_c10_i, arr_c11_i;
  logic           res_valid_o;
  logic           res_ready_i;
  logic [DIM-1:0] res_ti_o, res_tj_o;
  logic [AW-1:0]  res_c00_o, res_c01_o, res_c10_o, res_c11_o;
  logic           busy_o, done_o, err_o;

  systolic_tile_ctrl #(
    .DATA_WIDTH (DW),
    .ACCUM_WIDTH(AW),
    .DIM_W      (DIM),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .m_tiles_i       (m_tiles_i),
    .n_tiles_i       (n_tiles_i),
    .k_tiles_i       (k_tiles_i),
    .abort_i         (abort_i),
    .fetch_req_o     (fetch_req_o),
    .fetch_ti_o      (fetch_ti_o),
    .fetch_tj_o      (fetch_tj_o),
    .fetch_kt_o      (fetch_kt_o),
    .fetch_sub_o     (fetch_sub_o),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_a0_i      (fetch_a0_i),
    .fetch_a1_i      (fetch_a1_i),
    .fetch_b0_i      (fetch_b0_i),
    .fetch_b1_i      (fetch_b1_i),
    .arr_start_o     (arr_start_o),
    .arr_clear_o     (arr_clear_o),
    .arr_accumulate_o(arr_accumulate_o),
    .arr_a_valid_o   (arr_a_valid_o),
    .arr_b_valid_o   (arr_b_valid_o),
    .arr_a_row0_o    (arr_a_row0_o),
    .arr_a_row1_o    (arr_a_row1_o),
    .arr_b_col0_o    (arr_b_col0_o),
    .arr_b_col1_o    (arr_b_col1_o),
    .arr_done_i      (arr_done_i),
    .arr_c00_i       (arr_c00_i),
    .arr_c01_i       (arr_c01_i),
    .arr_c10_i       (arr_c10_i),
    .arr_c11_i       (arr_c11_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_ti_o        (res_ti_o),
    .res_tj_o        (res_tj_o),
    .res_c00_o       (res_c00_o),
    .res_c01_o       (res_c01_o),
    .res_c10_o       (res_c10_o),
    .res_c11_o       (res_c11_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DIM-1:0] ti;
    logic [DIM-1:0] tj;
    logic [AW-1:0]  c00;
    logic [AW-1:0]  c01;
    logic [AW-1:0]  c10;
    logic [AW-1:0]  c11;
  } res_t;

  res_t sb_q[$];
  res_t snap;
  bit   snap_ok;

  int n_cmp;
  int n_bad;

  int cyc, pend, nfed;
  int clr_cnt, st_cnt, fet_cnt, hs_cnt;
  int done_cnt, err_cnt, nrdy;
  int done_cyc, err_cyc, hs_cyc, fet_cyc;
  int stall_at, stall_left, stalled;
  bit no_done;
  logic [12:0] first_idx;
  logic        acc_seq[$];
  logic [3:0]  kt_seq[$];
  logic [AW-1:0] m00, m01, m10, m11;
  logic [AW-1:0] last_c[4];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] a_el(int r, int k);
    return 64'(2 * r + k + 1);
  endfunction

  function automatic logic [63:0] b_el(int k, int c);
    return 64'(2 * k + c + 5);
  endfunction

  function automatic logic [63:0] c_el(int r, int c, int kk);
    logic [63:0] s = '0;
    for (int k = 0; k < 2 * kk; k++) s += a_el(r, k) * b_el(k, c);
    return s;
  endfunction

  task automatic push_job(input int m, input int n, input int k);
    res_t e;
    for (int ti = 0; ti < m; ti++) begin
      for (int tj = 0; tj < n; tj++) begin
        e.ti  = DIM'(ti);
        e.tj  = DIM'(tj);
        e.c00 = c_el(2 * ti,     2 * tj,     k);
        e.c01 = c_el(2 * ti,     2 * tj + 1, k);
        e.c10 = c_el(2 * ti + 1, 2 * tj,     k);
        e.c11 = c_el(2 * ti + 1, 2 * tj + 1, k);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic clr_stats();
    clr_cnt = 0; st_cnt = 0; fet_cnt = 0; hs_cnt = 0;
    done_cnt = 0; err_cnt = 0; nrdy = 0; stalled = 0;
    done_cyc = 0; err_cyc = 0; hs_cyc = 0; fet_cyc = 0;
    first_idx = '1;
    acc_seq.delete();
    kt_seq.delete();
  endtask

  task automatic issue(input int m, input int n, input int k);
    @(negedge clk_i); #2;
    cmd_valid_i = 1'b1;
    m_tiles_i   = DIM'(m);
    n_tiles_i   = DIM'(n);
    k_tiles_i   = DIM'(k);
    @(negedge clk_i); #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int i = 0;
    while (done_cnt == 0 && err_cnt == 0 && i < bound) begin
      @(negedge clk_i); #2;
      i++;
    end
    chk(tag, 64'(done_cnt + err_cnt != 0), 64'd1);
    repeat (3) @(negedge clk_i);
    #2;
  endtask

  task automatic cmp_res(input string tag, input res_t e);
    chk({tag, "_tij"}, {56'd0, res_ti_o, res_tj_o}, {56'd0, e.ti, e.tj});
    chk({tag, "_c00"}, res_c00_o, e.c00);
    chk({tag, "_c01"}, res_c01_o, e.c01);
    chk({tag, "_c10"}, res_c10_o, e.c10);
    chk({tag, "_c11"}, res_c11_o, e.c11);
  endtask

  // Operand buffer, array model and result consumer, one step per cycle.
  task automatic env_loop();
    int r, c, k;
    res_t e;
    forever begin
      @(negedge clk_i);
      cyc++;
      fetch_valid_i = fetch_req_o && ($urandom_range(0, 3) != 0);
      r = 2 * int'(fetch_ti_o);
      c = 2 * int'(fetch_tj_o);
      k = 2 * int'(fetch_kt_o) + int'(fetch_sub_o);
      fetch_a0_i = DW'(a_el(r, k));
      fetch_a1_i = DW'(a_el(r + 1, k));
      fetch_b0_i = DW'(b_el(k, c));
      fetch_b1_i = DW'(b_el(k, c + 1));
      arr_done_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !no_done) arr_done_i = 1'b1;
      end
      if (res_valid_o && hs_cnt == stall_at && stall_left > 0) begin
        res_ready_i = 1'b0;
        stall_left--;
        stalled++;
      end else begin
        res_ready_i = 1'b1;
      end
      arr_c00_i = m00;
      arr_c01_i = m01;
      arr_c10_i = m10;
      arr_c11_i = m11;
      #1;
      if (!cmd_ready_o) nrdy++;
      if (arr_clear_o) begin
        clr_cnt++;
        m00 = '0; m01 = '0; m10 = '0; m11 = '0;
      end
      if (arr_start_o) begin
        st_cnt++;
        nfed = 0;
        acc_seq.push_back(arr_accumulate_o);
      end
      if (arr_a_valid_o && arr_b_valid_o) begin
        fet_cnt++;
        fet_cyc = cyc;
        if (fet_cnt == 1)
          first_idx = {fetch_ti_o, fetch_tj_o, fetch_kt_o, fetch_sub_o};
        kt_seq.push_back(fetch_kt_o);
        m00 += 64'(arr_a_row0_o) * 64'(arr_b_col0_o);
        m01 += 64'(arr_a_row0_o) * 64'(arr_b_col1_o);
        m10 += 64'(arr_a_row1_o) * 64'(arr_b_col0_o);
        m11 += 64'(arr_a_row1_o) * 64'(arr_b_col1_o);
        nfed++;
        if (nfed == 2) begin
          nfed = 0;
          pend = 2;
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err_o) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (res_valid_o) begin
        if (!res_ready_i && !snap_ok) begin
          snap = {res_ti_o, res_tj_o, res_c00_o,
                  res_c01_o, res_c10_o, res_c11_o};
          snap_ok = 1'b1;
        end else if (snap_ok) begin
          cmp_res("stable", snap);
          if (res_ready_i) snap_ok = 1'b0;
        end
        if (res_ready_i) begin
          hs_cnt++;
          hs_cyc = cyc;
          last_c[0] = res_c00_o;
          last_c[1] = res_c01_o;
          last_c[2] = res_c10_o;
          last_c[3] = res_c11_o;
          if (sb_q.size() == 0) begin
            chk("sb_extra", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            cmp_res("res", e);
          end
        end
      end
    end
  endtask

  initial begin
    int i;
    n_cmp = 0; n_bad = 0; cyc = 0; pend = 0; nfed = 0;
    stall_at = -1; stall_left = 0; no_done = 1'b0; snap_ok = 1'b0;
    m00 = '0; m01 = '0; m10 = '0; m11 = '0;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; abort_i = 1'b0;
    m_tiles_i = '0; n_tiles_i = '0; k_tiles_i = '0;
    fetch_valid_i = 1'b0; arr_done_i = 1'b0; res_ready_i = 1'b1;
    fetch_a0_i = '0; fetch_a1_i = '0; fetch_b0_i = '0; fetch_b1_i = '0;
    arr_c00_i = '0; arr_c01_i = '0; arr_c10_i = '0; arr_c11_i = '0;
    clr_stats();
    fork
      env_loop();
    join_none

    repeat (3) @(negedge clk_i);
    #2;
    chk("rst_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_pulses", 64'({done_o, err_o, arr_clear_o, arr_start_o}), 64'd0);
    chk("rst_valids", 64'({fetch_req_o, res_valid_o, arr_a_valid_o}), 64'd0);
    chk("rst_acc", 64'(arr_accumulate_o), 64'd0);
    rst_ni = 1'b1;

    // single tile, single pass
    clr_stats();
    push_job(1, 1, 1);
    issue(1, 1, 1);
    wait_end("t1_end", 300);
    chk("t1_c00", last_c[0], 64'd19);
    chk("t1_c01", last_c[1], 64'd22);
    chk("t1_c10", last_c[2], 64'd43);
    chk("t1_c11", last_c[3], 64'd50);
    chk("t1_clr", 64'(clr_cnt), 64'd1);
    chk("t1_start", 64'(st_cnt), 64'd1);
    chk("t1_fetch", 64'(fet_cnt), 64'd2);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_done_lat", 64'(done_cyc - hs_cyc), 64'd1);
    chk("t1_sb", 64'(sb_q.size()), 64'd0);

    // three K passes into one tile
    clr_stats();
    push_job(1, 1, 3);
    issue(1, 1, 3);
    wait_end("t2_end", 600);
    chk("t2_start", 64'(st_cnt), 64'd3);
    chk("t2_hs", 64'(hs_cnt), 64'd1);
    chk("t2_accn", 64'(acc_seq.size()), 64'd3);
    for (int j = 0; j < acc_seq.size() && j < 3; j++)
      chk("t2_acc", 64'(acc_seq[j]), (j == 0) ? 64'd0 : 64'd1);
    chk("t2_ktn", 64'(kt_seq.size()), 64'd6);
    for (int j = 0; j < kt_seq.size() && j < 6; j++)
      chk("t2_kt", 64'(kt_seq[j]), 64'(j / 2));

    // 2x3 tiles with the second result stalled
    clr_stats();
    stall_at = 1;
    stall_left = 5;
    push_job(2, 3, 1);
    issue(2, 3, 1);
    wait_end("t3_end", 1500);
    stall_at = -1;
    chk("t3_hs", 64'(hs_cnt), 64'd6);
    chk("t3_clr", 64'(clr_cnt), 64'd6);
    chk("t3_start", 64'(st_cnt), 64'd6);
    chk("t3_fetch", 64'(fet_cnt), 64'd12);
    chk("t3_stalled", 64'(stalled), 64'd5);
    chk("t3_done", 64'(done_cnt), 64'd1);
    chk("t3_done_lat", 64'(done_cyc - hs_cyc), 64'd1);
    chk("t3_sb", 64'(sb_q.size()), 64'd0);

    // zero K count rejected
    clr_stats();
    issue(1, 1, 0);
    wait_end("t4_end", 20);
    chk("t4_err", 64'(err_cnt), 64'd1);
    chk("t4_fetch", 64'(fet_cnt + st_cnt + clr_cnt), 64'd0);
    chk("t4_nrdy", 64'(nrdy), 64'd0);
    chk("t4_done", 64'(done_cnt), 64'd0);

    // array never finishes
    clr_stats();
    no_done = 1'b1;
    issue(1, 1, 1);
    wait_end("t5_end", 300);
    no_done = 1'b0;
    chk("t5_err", 64'(err_cnt), 64'd1);
    chk("t5_lat", 64'(err_cyc - fet_cyc), 64'(TMO + 1));
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_done", 64'(done_cnt + hs_cnt), 64'd0);

    // abort in the middle of tile (1,0), then a fresh job
    clr_stats();
    push_job(2, 1, 1);
    issue(2, 1, 1);
    i = 0;
    while (!(fetch_req_o && fetch_ti_o == 4'd1) && i < 500) begin
      @(negedge clk_i); #2;
      i++;
    end
    chk("t6_reach", 64'(fetch_req_o && fetch_ti_o == 4'd1), 64'd1);
    abort_i = 1'b1;
    @(negedge clk_i); #2;
    abort_i = 1'b0;
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_quiet", 64'({fetch_req_o, res_valid_o, done_o, err_o}), 64'd0);
    repeat (10) @(negedge clk_i);
    #2;
    chk("t6_noend", 64'(done_cnt + err_cnt), 64'd0);
    chk("t6_hs", 64'(hs_cnt), 64'd1);
    sb_q.delete();
    clr_stats();
    push_job(1, 1, 1);
    issue(1, 1, 1);
    wait_end("t6b_end", 300);
    chk("t6b_idx", 64'(first_idx), 64'd0);
    chk("t6b_done", 64'(done_cnt), 64'd1);
    chk("t6b_hs", 64'(hs_cnt), 64'd1);
    chk("t6b_sb", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
